// File: rtl/smag_addsub_pipe_if.sv
// Handshake bundle for the sign-magnitude add/subtract pipeline: operand beat
// in, result beat out, plus the completed-operation counter.
interface smag_addsub_pipe_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     op1;
    logic [W-1:0]     op2;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     res;
    logic             ovf;
    logic [CNT_W-1:0] ops_cnt;

    modport master (
        output in_valid, op1, op2, sub, out_ready,
        input  in_ready, out_valid, res, ovf, ops_cnt
    );

    modport slave (
        input  in_valid, op1, op2, sub, out_ready,
        output in_ready, out_valid, res, ovf, ops_cnt
    );
endinterface

// File: rtl/smag_addsub_pipe.sv
// Two-stage elastic sign-magnitude adder/subtractor. S1 holds both operands in
// (W+1)-bit two's complement, S2 holds the sign-magnitude result and overflow.
module smag_addsub_pipe #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    smag_addsub_pipe_if.slave  io_bus
);

    localparam logic [W:0]       ONE_TW  = {{W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    function automatic logic [W:0] tc_neg(input logic [W:0] v);
        return ~v + ONE_TW;
    endfunction

    // Negative zero negates to zero, so it needs no special case here.
    function automatic logic [W:0] sm_to_tc(input logic [W-1:0] sm);
        logic [W:0] mag_v;
        mag_v = {2'b00, sm[W-2:0]};
        return sm[W-1] ? tc_neg(mag_v) : mag_v;
    endfunction

    // Returns {ovf, sign, magnitude}; sign is suppressed for a zero magnitude.
    function automatic logic [W:0] tc_to_sm(input logic [W:0] s);
        logic [W:0]   abs_v;
        logic [W-2:0] mag_v;
        logic         ovf_v;
        logic         sgn_v;
        abs_v = s[W] ? tc_neg(s) : s;
        mag_v = abs_v[W-2:0];
        ovf_v = abs_v[W] | abs_v[W-1];
        sgn_v = s[W] & (|mag_v);
        return {ovf_v, sgn_v, mag_v};
    endfunction

    logic             r_rdy_en;
    logic             r_s1_valid;
    logic [W:0]       r_s1_a;
    logic [W:0]       r_s1_b;
    logic             r_s2_valid;
    logic [W-1:0]     r_s2_res;
    logic             r_s2_ovf;
    logic [CNT_W-1:0] r_ops_cnt;

    logic             w_out_fire;
    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_in_fire;
    logic [W:0]       w_a_tc;
    logic [W:0]       w_b_tc;
    logic [W:0]       w_sum;
    logic [W:0]       w_sm;

    // Handshake/advance decisions; in_ready looks only at state and out_ready.
    always_comb begin
        w_out_fire = r_s2_valid & io_bus.out_ready;
        w_s2_adv   = r_s1_valid & (~r_s2_valid | io_bus.out_ready);
        w_in_ready = r_rdy_en & (~r_s1_valid | w_s2_adv);
        w_in_fire  = io_bus.in_valid & w_in_ready;
    end

    // Operand conversion into S1 and the S1 sum/convert feeding S2.
    always_comb begin
        w_a_tc = sm_to_tc(io_bus.op1);
        w_b_tc = io_bus.sub ? tc_neg(sm_to_tc(io_bus.op2)) : sm_to_tc(io_bus.op2);
        w_sum  = r_s1_a + r_s1_b;
        w_sm   = tc_to_sm(w_sum);
    end

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    // Stage 1: operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= w_a_tc;
            r_s1_b     <= w_b_tc;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register, held stable while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_res   <= '0;
            r_s2_ovf   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= 1'b1;
            r_s2_res   <= w_sm[W-1:0];
            r_s2_ovf   <= w_sm[W];
        end else if (w_out_fire) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Completed-output counter, wrapping naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_cnt <= '0;
        end else if (w_out_fire) begin
            r_ops_cnt <= r_ops_cnt + ONE_CNT;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_s2_valid;
    assign io_bus.res       = r_s2_res;
    assign io_bus.ovf       = r_s2_ovf;
    assign io_bus.ops_cnt   = r_ops_cnt;

endmodule
